// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode encodings, default widths and the bubble instruction.
package cpu_pkg;

    localparam logic [2:0] LOAD     = 3'b111;
    localparam logic [2:0] STORE    = 3'b110;
    localparam logic [2:0] BRANCH   = 3'b101;
    localparam logic [2:0] ADD      = 3'b100;
    localparam logic [2:0] SUBTRACT = 3'b011;
    localparam logic [2:0] AND      = 3'b010;
    localparam logic [2:0] OR       = 3'b001;
    localparam logic [2:0] NOOP     = 3'b000;

    localparam int unsigned DEF_ADDR_W = 11;
    localparam int unsigned DEF_DATA_W = 32;

    localparam logic [31:0] NOOP_INSTR = 32'h0;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding {pc, instruction} pairs; flush beats push/pop.
module fetch_fifo #(
    parameter int unsigned WIDTH = 43,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q, wr_ptr_q;
    logic [PW:0]      count_q;
    logic             do_pop;

    assign empty  = (count_q == '0);
    assign full   = (count_q == (PW+1)'(DEPTH));
    assign count  = count_q;
    assign rdata  = mem_q[rd_ptr_q];
    assign do_pop = pop && !empty;

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (resetn || flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            unique case ({push, do_pop})
                2'b10:   count_q <= count_q + (PW+1)'(1);
                2'b01:   count_q <= count_q - (PW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/fetch_buffer.sv
// Instruction prefetch stage: sequential fetch, FIFO buffering, branch redirect with flush.
// Optional FETCH_NOOP_FILL_EN forces instr/instr_pc to zero whenever instr_valid is low.
module fetch_buffer
    import cpu_pkg::*;
#(
    parameter int unsigned       ADDR_W   = DEF_ADDR_W,
    parameter int unsigned       DATA_W   = DEF_DATA_W,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              branch_valid,
    input  logic [ADDR_W-1:0] branch_address,
    output logic              read_mem,
    output logic [ADDR_W-1:0] mem_radrs,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready
);

    localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;
    localparam int unsigned ENTRY_W = ADDR_W + DATA_W;

    logic [ADDR_W-1:0]  fetch_pc_q, inflight_pc_q;
    logic               inflight_q;
    logic [CNT_W-1:0]   fifo_count;
    logic               fifo_empty, fifo_full;
    logic [ENTRY_W-1:0] fifo_head;
    logic               pop;
    logic [DATA_W-1:0]  head_instr;
    logic [ADDR_W-1:0]  head_pc;

    // An outstanding read already owns a FIFO slot, so it counts against capacity.
    assign read_mem  = !resetn && !branch_valid &&
                       ((32'(fifo_count) + 32'(inflight_q)) < DEPTH);
    assign mem_radrs = fetch_pc_q;

    assign instr_valid = !fifo_empty;
    assign pop         = instr_valid && instr_ready;
    assign {head_pc, head_instr} = fifo_head;

    always_ff @(posedge clk) begin
        if (resetn) begin
            fetch_pc_q    <= RESET_PC;
            inflight_pc_q <= '0;
            inflight_q    <= 1'b0;
        end else if (branch_valid) begin
            fetch_pc_q <= branch_address;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= read_mem;
            if (read_mem) begin
                inflight_pc_q <= fetch_pc_q;
                fetch_pc_q    <= fetch_pc_q + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn && !branch_valid) begin
            assert (!(inflight_q && fifo_full && !pop))
                else $error("fetch_buffer: push into full FIFO");
        end
    end

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .flush  (branch_valid),
        .push   (inflight_q),
        .pop    (pop),
        .wdata  ({inflight_pc_q, mem_rdata}),
        .rdata  (fifo_head),
        .count  (fifo_count),
        .empty  (fifo_empty),
        .full   (fifo_full)
    );

`ifdef FETCH_NOOP_FILL_EN
    always_comb begin
        instr    = NOOP_INSTR[DATA_W-1:0];
        instr_pc = '0;
        if (instr_valid) begin
            instr    = head_instr;
            instr_pc = head_pc;
        end
    end
`else
    logic [DATA_W-1:0] last_instr_q;
    logic [ADDR_W-1:0] last_pc_q;

    // Remember the head so an empty FIFO keeps showing the last delivered word.
    always_ff @(posedge clk) begin
        if (resetn) begin
            last_instr_q <= '0;
            last_pc_q    <= '0;
        end else if (instr_valid) begin
            last_instr_q <= head_instr;
            last_pc_q    <= head_pc;
        end
    end

    always_comb begin
        instr    = last_instr_q;
        instr_pc = last_pc_q;
        if (instr_valid) begin
            instr    = head_instr;
            instr_pc = head_pc;
        end
    end
`endif

endmodule
